// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the IF/ID stall controller.
// Contents:
//   stall_state_e  - 2-bit stall state (RUN, HAZ, MEMW, FLUSH)
//   NOP_INSTR_DEF  - instruction word placed in ID on flush or reset
//                    (ARM AND r0,r0,r0)
//   FREEZE_CNT_W   - width of the consecutive-freeze counter
//   STAT_CNT_W     - width of the optional statistics counters
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HAZ   = 2'd1,
    ST_MEMW  = 2'd2,
    ST_FLUSH = 2'd3
  } stall_state_e;

  localparam logic [31:0] NOP_INSTR_DEF = 32'hE000_0000;
  localparam int          FREEZE_CNT_W  = 8;
  localparam int          STAT_CNT_W    = 16;

endpackage

// File: rtl/sat_cnt.sv
// Parameterised saturating counter.
// Priority: reset > clear > increment > hold. The count stops at all-ones.
// Ports:
//   clk  - clock
//   rst  - synchronous active-low reset
//   clr  - synchronous clear to zero
//   inc  - increment by one (ignored once saturated)
//   cnt  - registered count value
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_cnt;

  // Counter register: reset, clear, saturating increment or hold
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= {W{1'b0}};
    end else if (clr) begin
      r_cnt <= {W{1'b0}};
    end else if (inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/if_id_stall_ctrl.sv
// IF/ID stall controller. Owns the IF/ID pipeline register, the PC write
// enable and bubble insertion into ID/EXE. Arbitrates, highest first:
// reset > memory wait > branch flush > hazard freeze > run.
// Optional build macro: IF_ID_STALL_STATS_EN adds stat_haz / stat_mem
// saturating counters of freeze-case and memory-wait cycles.
// Ports:
//   clk, rst          - clock, synchronous active-low reset
//   freeze            - hazard unit freeze request (same cycle)
//   flush             - branch taken in EXE
//   mem_ready         - SRAM ready; low stalls the whole pipe
//   if_pc, if_instr   - PC+4 and instruction from IF
//   pc_en             - PC write enable (combinational)
//   pipe_en           - downstream pipeline register enable (combinational)
//   bubble            - zero ID/EXE control bits (combinational)
//   id_pc, id_instr   - registered IF/ID contents
//   id_valid          - registered; 0 marks id_instr as a NOP/bubble
//   state             - registered case taken in the previous cycle
//   err_stuck         - sticky: freeze lasted longer than MAX_FREEZE
module if_id_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int                PC_W       = 32,
  parameter int                INSTR_W    = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF),
  parameter int                MAX_FREEZE = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               flush,
  input  logic               mem_ready,
  input  logic [PC_W-1:0]    if_pc,
  input  logic [INSTR_W-1:0] if_instr,
  output logic               pc_en,
  output logic               pipe_en,
  output logic               bubble,
  output logic [PC_W-1:0]    id_pc,
  output logic [INSTR_W-1:0] id_instr,
  output logic               id_valid,
  output logic [1:0]         state,
  output logic               err_stuck
`ifdef IF_ID_STALL_STATS_EN
  ,
  output logic [STAT_CNT_W-1:0] stat_haz,
  output logic [STAT_CNT_W-1:0] stat_mem
`endif
);

  localparam logic [FREEZE_CNT_W-1:0] FRZ_LIMIT = FREEZE_CNT_W'(MAX_FREEZE);

  stall_state_e              w_case;
  logic                      w_pc_en;
  logic                      w_pipe_en;
  logic                      w_bubble;
  logic                      w_frz_clr;
  logic                      w_frz_inc;
  logic [FREEZE_CNT_W-1:0]   w_frz_cnt;

  stall_state_e              r_state;
  logic [PC_W-1:0]           r_id_pc;
  logic [INSTR_W-1:0]        r_id_instr;
  logic                      r_id_valid;
  logic                      r_err_stuck;

  // Case selection and combinational enables for the current cycle
  always_comb begin
    w_case    = ST_RUN;
    w_pc_en   = 1'b1;
    w_pipe_en = 1'b1;
    w_bubble  = 1'b0;
    if (!mem_ready) begin
      // Whole pipe frozen; pending flush/freeze stay held by their sources
      w_case    = ST_MEMW;
      w_pc_en   = 1'b0;
      w_pipe_en = 1'b0;
      w_bubble  = 1'b0;
    end else if (flush) begin
      // Flush wins over freeze: the frozen consumer is being squashed
      w_case    = ST_FLUSH;
      w_pc_en   = 1'b1;
      w_pipe_en = 1'b1;
      w_bubble  = 1'b1;
    end else if (freeze) begin
      w_case    = ST_HAZ;
      w_pc_en   = 1'b0;
      w_pipe_en = 1'b1;
      w_bubble  = 1'b1;
    end else begin
      w_case    = ST_RUN;
      w_pc_en   = 1'b1;
      w_pipe_en = 1'b1;
      w_bubble  = 1'b0;
    end
  end

  // Freeze counter clears on run/flush and holds through memory wait
  assign w_frz_inc = (w_case == ST_HAZ);
  assign w_frz_clr = (w_case == ST_RUN) || (w_case == ST_FLUSH);

  sat_cnt #(.W(FREEZE_CNT_W)) u_frz_cnt (
    .clk (clk),
    .rst (rst),
    .clr (w_frz_clr),
    .inc (w_frz_inc),
    .cnt (w_frz_cnt)
  );

  // State register: records the case taken this cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_case;
    end
  end

  // IF/ID pipeline register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_id_pc    <= {PC_W{1'b0}};
      r_id_instr <= NOP_INSTR;
      r_id_valid <= 1'b0;
    end else begin
      case (w_case)
        ST_RUN: begin
          r_id_pc    <= if_pc;
          r_id_instr <= if_instr;
          r_id_valid <= 1'b1;
        end
        ST_FLUSH: begin
          r_id_pc    <= if_pc;
          r_id_instr <= NOP_INSTR;
          r_id_valid <= 1'b0;
        end
        default: begin
          // HAZ and MEMW hold the current instruction in ID
          r_id_pc    <= r_id_pc;
          r_id_instr <= r_id_instr;
          r_id_valid <= r_id_valid;
        end
      endcase
    end
  end

  // Sticky runaway-freeze flag: a further freeze once the limit is reached
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_err_stuck <= 1'b0;
    end else if (w_frz_inc && (w_frz_cnt >= FRZ_LIMIT)) begin
      r_err_stuck <= 1'b1;
    end else begin
      r_err_stuck <= r_err_stuck;
    end
  end

`ifdef IF_ID_STALL_STATS_EN
  sat_cnt #(.W(STAT_CNT_W)) u_stat_haz (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (w_case == ST_HAZ),
    .cnt (stat_haz)
  );

  sat_cnt #(.W(STAT_CNT_W)) u_stat_mem (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (w_case == ST_MEMW),
    .cnt (stat_mem)
  );
`endif

  assign pc_en     = w_pc_en;
  assign pipe_en   = w_pipe_en;
  assign bubble    = w_bubble;
  assign id_pc     = r_id_pc;
  assign id_instr  = r_id_instr;
  assign id_valid  = r_id_valid;
  assign state     = r_state;
  assign err_stuck = r_err_stuck;

endmodule

// File: tb/tb_if_id_stall_ctrl.sv
// Directed self-checking bench for if_id_stall_ctrl.
module tb_if_id_stall_ctrl;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        flush;
  logic        mem_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        pc_en;
  logic        pipe_en;
  logic        bubble;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_valid;
  logic [1:0]  state;
  logic        err_stuck;
`ifdef IF_ID_STALL_STATS_EN
  logic [15:0] stat_haz;
  logic [15:0] stat_mem;
`endif

  int n_asrt = 0;
  int n_fail = 0;

  localparam logic [31:0] NOP = 32'hE000_0000;

  if_id_stall_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .freeze    (freeze),
    .flush     (flush),
    .mem_ready (mem_ready),
    .if_pc     (if_pc),
    .if_instr  (if_instr),
    .pc_en     (pc_en),
    .pipe_en   (pipe_en),
    .bubble    (bubble),
    .id_pc     (id_pc),
    .id_instr  (id_instr),
    .id_valid  (id_valid),
    .state     (state),
    .err_stuck (err_stuck)
`ifdef IF_ID_STALL_STATS_EN
    ,
    .stat_haz  (stat_haz),
    .stat_mem  (stat_mem)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b0;
    freeze    = 1'b0;
    flush     = 1'b0;
    mem_ready = 1'b1;
    if_pc     = 32'h0000_0000;
    if_instr  = 32'h1234_5678;

    // Reset held for two edges
    tick();
    tick();
    chk("rst_id_pc",    {31'd0, 1'b0} | id_pc, 32'h0);
    chk("rst_id_instr", id_instr, NOP);
    chk("rst_id_valid", {31'd0, id_valid}, 32'h0);
    chk("rst_state",    {30'd0, state}, 32'h0);
    chk("rst_err",      {31'd0, err_stuck}, 32'h0);
    rst = 1'b1;
    #1;
    chk("rel_pc_en",    {31'd0, pc_en}, 32'h1);

    // Run loads IF/ID
    if_pc    = 32'h0000_0004;
    if_instr = 32'hE280_1001;
    #1;
    chk("run_bubble",   {31'd0, bubble}, 32'h0);
    chk("run_pipe_en",  {31'd0, pipe_en}, 32'h1);
    tick();
    chk("run_id_pc",    id_pc, 32'h0000_0004);
    chk("run_id_instr", id_instr, 32'hE280_1001);
    chk("run_id_valid", {31'd0, id_valid}, 32'h1);
    chk("run_state",    {30'd0, state}, 32'h0);

    // Single freeze cycle holds IF/ID and inserts a bubble
    freeze   = 1'b1;
    if_pc    = 32'h0000_0008;
    if_instr = 32'hE280_2002;
    #1;
    chk("frz_pc_en",    {31'd0, pc_en}, 32'h0);
    chk("frz_bubble",   {31'd0, bubble}, 32'h1);
    chk("frz_pipe_en",  {31'd0, pipe_en}, 32'h1);
    tick();
    chk("frz_id_instr", id_instr, 32'hE280_1001);
    chk("frz_id_pc",    id_pc, 32'h0000_0004);
    chk("frz_state",    {30'd0, state}, 32'h1);
    freeze = 1'b0;
    tick();
    chk("rerun_id_pc",    id_pc, 32'h0000_0008);
    chk("rerun_id_instr", id_instr, 32'hE280_2002);
    chk("rerun_state",    {30'd0, state}, 32'h0);

    // Five freeze cycles, then flush+freeze must clear the freeze count
    freeze = 1'b1;
    repeat (5) tick();
    chk("frz5_err",     {31'd0, err_stuck}, 32'h0);
    flush    = 1'b1;
    if_pc    = 32'h0000_000C;
    if_instr = 32'hE3A0_0001;
    #1;
    chk("fl_pc_en",     {31'd0, pc_en}, 32'h1);
    chk("fl_bubble",    {31'd0, bubble}, 32'h1);
    tick();
    chk("fl_id_instr",  id_instr, NOP);
    chk("fl_id_valid",  {31'd0, id_valid}, 32'h0);
    chk("fl_id_pc",     id_pc, 32'h0000_000C);
    chk("fl_state",     {30'd0, state}, 32'h3);
    flush = 1'b0;
    repeat (8) tick();
    chk("fl_cnt_clear_err", {31'd0, err_stuck}, 32'h0);
    chk("fl_hold_id_pc",    id_pc, 32'h0000_000C);
    freeze   = 1'b0;
    if_pc    = 32'h0000_0010;
    if_instr = 32'hE1A0_0000;
    tick();
    chk("run2_id_pc",    id_pc, 32'h0000_0010);
    chk("run2_id_valid", {31'd0, id_valid}, 32'h1);

    // Three freezes, then memory wait with freeze and flush pending
    freeze = 1'b1;
    repeat (3) tick();
    mem_ready = 1'b0;
    flush     = 1'b1;
    if_pc     = 32'h0000_0014;
    if_instr  = 32'hE590_1000;
    #1;
    chk("mw_pipe_en",   {31'd0, pipe_en}, 32'h0);
    chk("mw_pc_en",     {31'd0, pc_en}, 32'h0);
    chk("mw_bubble",    {31'd0, bubble}, 32'h0);
    repeat (3) tick();
    chk("mw_state",     {30'd0, state}, 32'h2);
    chk("mw_id_pc",     id_pc, 32'h0000_0010);
    chk("mw_id_instr",  id_instr, 32'hE1A0_0000);
    chk("mw_id_valid",  {31'd0, id_valid}, 32'h1);
    // Count was 3 and held; five more freezes reach the limit exactly
    mem_ready = 1'b1;
    flush     = 1'b0;
    repeat (5) tick();
    chk("mw_cnt_hold_err0", {31'd0, err_stuck}, 32'h0);
    tick();
    chk("mw_cnt_hold_err1", {31'd0, err_stuck}, 32'h1);

    // Reset mid-stall leaves no residual state
    rst = 1'b0;
    tick();
    chk("rst2_err",      {31'd0, err_stuck}, 32'h0);
    chk("rst2_state",    {30'd0, state}, 32'h0);
    chk("rst2_id_valid", {31'd0, id_valid}, 32'h0);
    chk("rst2_id_instr", id_instr, NOP);
    rst    = 1'b1;
    freeze = 1'b0;
    tick();

    // Freeze held exactly MAX_FREEZE cycles: no error
    freeze = 1'b1;
    repeat (8) tick();
    chk("frz8_err",     {31'd0, err_stuck}, 32'h0);
    freeze = 1'b0;
    tick();
    chk("frz8_post_err", {31'd0, err_stuck}, 32'h0);

    // Freeze held nine cycles: error sets and is sticky
    freeze = 1'b1;
    repeat (8) tick();
    chk("frz9_at8_err", {31'd0, err_stuck}, 32'h0);
    tick();
    chk("frz9_err",     {31'd0, err_stuck}, 32'h1);
    freeze = 1'b0;
    repeat (2) tick();
    chk("sticky_err",   {31'd0, err_stuck}, 32'h1);
    chk("sticky_state", {30'd0, state}, 32'h0);
    rst = 1'b0;
    tick();
    chk("rst3_err",     {31'd0, err_stuck}, 32'h0);
    rst = 1'b1;
    tick();
    chk("post_rst_valid", {31'd0, id_valid}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
